// File: rtl/spi_bridge_pkg.sv
// spi_bridge_pkg: shared state encoding and constants for the SPI register bridge.
package spi_bridge_pkg;
    localparam int BYTE_W = 8;
    localparam int CMD_RD_BIT = 7;
    typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;
endpackage

// File: rtl/spi_reg_bridge_if.sv
// spi_reg_bridge_if: byte-level handshake between the SPI peripheral (master) and the bridge (slave).
interface spi_reg_bridge_if;
    import spi_bridge_pkg::*;
    logic              csn_pad;
    logic              DRDY;
    logic [BYTE_W-1:0] d_recieved;
    logic [BYTE_W-1:0] d_to_send;
    logic              DWRITTEN;
    modport master (output csn_pad, DRDY, d_recieved, input d_to_send, DWRITTEN);
    modport slave (input csn_pad, DRDY, d_recieved, output d_to_send, DWRITTEN);
endinterface

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer followed by registered rising/falling edge pulses.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [2:0] sh;
    // Flops clear to 0 so a line already low at reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sh   <= {sh[1:0], d};
            rise <= sh[1] & ~sh[2];
            fall <= ~sh[1] & sh[2];
        end
    end
endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: parses chip-select framed SPI bytes into register bank reads and writes.
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int                NUM_REGS = 16,
    parameter logic [BYTE_W-1:0] DEV_ID   = 8'h5A
) (
    input  logic                         m_clk,
    input  logic                         rst_n,
    spi_reg_bridge_if.slave              spi,
    output logic [NUM_REGS*BYTE_W-1:0]   regs_flat,
    output logic                         wr_stb,
    output logic [$clog2(NUM_REGS)-1:0]  wr_addr
);
    localparam int AW = $clog2(NUM_REGS);
    state_t            state;
    logic [AW-1:0]     ptr;
    logic [AW-1:0]     cmd_addr;
    logic [BYTE_W-1:0] mem [NUM_REGS];
    logic [BYTE_W-1:0] tx_q;
    logic              tx_vld;
    logic              byte_ev;
    logic              frame_end;
    logic              frame_start;
    logic              unused_drdy_fall;
    logic              unused_rx_bits;
    sync_edge u_drdy (.clk(m_clk), .rst_n, .d(spi.DRDY), .rise(byte_ev), .fall(unused_drdy_fall));
    sync_edge u_csn (.clk(m_clk), .rst_n, .d(spi.csn_pad), .rise(frame_end), .fall(frame_start));
    assign cmd_addr        = spi.d_recieved[AW-1:0];
    assign unused_rx_bits  = ^spi.d_recieved;
    assign spi.d_to_send   = tx_q;
    assign spi.DWRITTEN    = tx_vld;
    function automatic logic [BYTE_W-1:0] rd_reg(input logic [AW-1:0] a);
        return (a == '0) ? DEV_ID : mem[a];
    endfunction
    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            if (g == 0) begin : g_id
                assign regs_flat[BYTE_W-1:0] = DEV_ID;
            end else begin : g_reg
                assign regs_flat[g*BYTE_W +: BYTE_W] = mem[g];
            end
        end
    endgenerate
    // The frame-end override sits last so a coincident byte is fully processed before returning to IDLE.
    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            tx_q    <= '0;
            tx_vld  <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else begin
            wr_stb <= 1'b0;
            if (byte_ev) tx_vld <= 1'b0;
            case (state)
                IDLE: if (frame_start) begin
                    state  <= CMD;
                    tx_q   <= '0;
                    tx_vld <= 1'b1;
                end
                CMD: if (byte_ev) begin
                    ptr <= cmd_addr;
                    if (spi.d_recieved[CMD_RD_BIT]) begin
                        state  <= RD;
                        tx_q   <= rd_reg(cmd_addr);
                        tx_vld <= 1'b1;
                    end else begin
                        state <= WR;
                    end
                end
                WR: if (byte_ev) begin
                    if (ptr != '0) begin
                        mem[ptr] <= spi.d_recieved;
                        wr_stb   <= 1'b1;
                        wr_addr  <= ptr;
                    end
                    ptr <= ptr + 1'b1;
                end
                RD: if (byte_ev) begin
                    ptr    <= ptr + 1'b1;
                    tx_q   <= rd_reg(ptr + 1'b1);
                    tx_vld <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (frame_end) begin
                state  <= IDLE;
                tx_q   <= '0;
                tx_vld <= 1'b0;
            end
        end
    end
endmodule
